// File: rtl/data_ram_resp.sv
// data_ram_resp: responder for the core's data-memory request port.
// Single-port synchronous SRAM with one cycle of read latency. Stores
// complete in the request cycle. A load that misses the last-read buffer
// stalls for exactly one cycle. Loads return the full aligned word.
// Optional fault checking is enabled with `define DATA_RAM_ERR_EN.
module data_ram_resp #(
   parameter int          AW   = 12,
   parameter logic [31:0] BASE = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ram_ce_i,
   input  logic        ram_we_i,
   input  logic [2:0]  ram_sel_i,
   input  logic [31:0] ram_addr_i,
   input  logic [31:0] ram_data_i,
   output logic [31:0] ram_data_o,
   output logic        stall_req_o,
   output logic        err_o
);

   typedef enum logic {IDLE, RDATA} state_t;

   state_t          state_q, state_d;
   logic [31:0]     mem_q [0:(2**AW)-1];
   logic [31:0]     sram_q;
   logic [31:0]     rd_buf_q;
   logic [AW-1:0]   tag_q;
   logic            tag_v_q;

   logic [31:0]     rel;
   logic [AW-1:0]   widx;
   logic [1:0]      off;
   logic [3:0]      be;
   logic [31:0]     wd;
   logic            bad_fmt;
   logic            fault;
   logic            hit;
   logic            wr_en, rd_en, fill, tag_clr;

   assign rel  = ram_addr_i - BASE;
   assign widx = rel[AW+1:2];
   assign off  = ram_addr_i[1:0];
   assign hit  = tag_v_q && (tag_q == widx);

   // Lane enables and replicated write data; misaligned or illegal formats write nothing.
   always_comb begin
      be      = 4'b0000;
      wd      = ram_data_i;
      bad_fmt = 1'b0;
      unique case (ram_sel_i)
         3'b000: begin
            be = 4'b0001 << off;
            wd = {4{ram_data_i[7:0]}};
         end
         3'b001: begin
            wd = {2{ram_data_i[15:0]}};
            if (off[0]) bad_fmt = 1'b1;
            else        be      = off[1] ? 4'b1100 : 4'b0011;
         end
         3'b010: begin
            if (off != 2'b00) bad_fmt = 1'b1;
            else              be      = 4'b1111;
         end
         default: bad_fmt = 1'b1;
      endcase
   end

`ifdef DATA_RAM_ERR_EN
   // Out-of-range, misaligned and illegal-sel accesses fault instead of wrapping.
   assign fault = bad_fmt || (|rel[31:AW+2]);
`else
   // Out-of-range addresses simply wrap; bad formats are dropped via be.
   assign fault = 1'b0;
`endif

   // Next-state and outputs; RDATA ignores the (still held) request as a new access.
   always_comb begin
      state_d     = state_q;
      ram_data_o  = rd_buf_q;
      stall_req_o = 1'b0;
      err_o       = 1'b0;
      wr_en       = 1'b0;
      rd_en       = 1'b0;
      fill        = 1'b0;
      tag_clr     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (ram_ce_i) begin
               if (fault) begin
                  err_o      = 1'b1;
                  ram_data_o = 32'h0;
               end else if (ram_we_i) begin
                  wr_en   = |be;
                  tag_clr = hit;
               end else if (!hit) begin
                  rd_en       = 1'b1;
                  stall_req_o = 1'b1;
                  state_d     = RDATA;
               end
            end
         end
         RDATA: begin
            ram_data_o = sram_q;
            fill       = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // SRAM array: byte-masked write, registered read. Contents are never reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++)
            if (be[i]) mem_q[widx][8*i +: 8] <= wd[8*i +: 8];
      end
      if (rd_en) sram_q <= mem_q[widx];
   end

   // State, last-read buffer and its tag; reset abandons any read in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         rd_buf_q <= 32'h0;
         tag_q    <= '0;
         tag_v_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (fill) begin
            rd_buf_q <= sram_q;
            tag_q    <= widx;
            tag_v_q  <= 1'b1;
         end else if (tag_clr) begin
            tag_v_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_data_ram_resp.sv
// Directed bench for data_ram_resp: reset, store/load latency, byte/half
// merges, last-read-buffer hit/miss, reset during RDATA, dropped/faulting
// accesses. Expectations follow DATA_RAM_ERR_EN if the macro is defined.
module tb_data_ram_resp;

   logic        clk = 1'b0;
   logic        rst;
   logic        ram_ce_i, ram_we_i;
   logic [2:0]  ram_sel_i;
   logic [31:0] ram_addr_i, ram_data_i;
   logic [31:0] ram_data_o;
   logic        stall_req_o, err_o;

   int checks = 0;
   int errors = 0;

`ifdef DATA_RAM_ERR_EN
   localparam bit ERR = 1'b1;
`else
   localparam bit ERR = 1'b0;
`endif

   data_ram_resp #(.AW(12), .BASE(32'h0)) dut (
      .clk         (clk),
      .rst         (rst),
      .ram_ce_i    (ram_ce_i),
      .ram_we_i    (ram_we_i),
      .ram_sel_i   (ram_sel_i),
      .ram_addr_i  (ram_addr_i),
      .ram_data_i  (ram_data_i),
      .ram_data_o  (ram_data_o),
      .stall_req_o (stall_req_o),
      .err_o       (err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One store request; checks the same-cycle response.
   task automatic store(input string tag, input logic [2:0] sel, input logic [31:0] addr,
                        input logic [31:0] data, input bit exp_err);
      ram_ce_i = 1'b1; ram_we_i = 1'b1; ram_sel_i = sel;
      ram_addr_i = addr; ram_data_i = data;
      @(negedge clk);
      chk({tag, ".stall"}, {31'b0, stall_req_o}, 32'd0);
      chk({tag, ".err"},   {31'b0, err_o},       {31'b0, exp_err});
      if (exp_err) chk({tag, ".data"}, ram_data_o, 32'h0);
      @(posedge clk); #1;
      ram_ce_i = 1'b0;
   endtask

   // One word load; miss expects one stall cycle then data in RDATA.
   task automatic load(input string tag, input logic [31:0] addr, input bit miss,
                       input bit chk_data, input logic [31:0] exp);
      ram_ce_i = 1'b1; ram_we_i = 1'b0; ram_sel_i = 3'b010; ram_addr_i = addr;
      @(negedge clk);
      chk({tag, ".err"},   {31'b0, err_o},       32'd0);
      chk({tag, ".stall"}, {31'b0, stall_req_o}, {31'b0, miss});
      if (miss) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk({tag, ".stall2"}, {31'b0, stall_req_o}, 32'd0);
      end
      if (chk_data) chk({tag, ".data"}, ram_data_o, exp);
      @(posedge clk); #1;
      ram_ce_i = 1'b0;
   endtask

   initial begin
      rst = 1'b1; ram_ce_i = 1'b0; ram_we_i = 1'b0; ram_sel_i = 3'b010;
      ram_addr_i = 32'h0; ram_data_i = 32'h0;

      // T1 reset
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("t1.stall", {31'b0, stall_req_o}, 32'd0);
      chk("t1.err",   {31'b0, err_o},       32'd0);
      chk("t1.data",  ram_data_o,           32'h0);
      @(posedge clk); #1;
      load("t1.lw", 32'h100, 1'b1, 1'b0, 32'h0);

      // T2 store word then miss, then hit
      store("t2.sw", 3'b010, 32'h100, 32'hDEADBEEF, 1'b0);
      load("t2.lw1", 32'h100, 1'b1, 1'b1, 32'hDEADBEEF);
      load("t2.lw2", 32'h100, 1'b0, 1'b1, 32'hDEADBEEF);

      // T3 byte store into lane 1 clears the tag
      store("t3.sb", 3'b000, 32'h101, 32'h0000005A, 1'b0);
      load("t3.lw", 32'h100, 1'b1, 1'b1, 32'hDEAD5AEF);

      // T4 half store upper lanes; unrelated store keeps the tag
      store("t4.sh", 3'b001, 32'h102, 32'h00001234, 1'b0);
      load("t4.lw1", 32'h100, 1'b1, 1'b1, 32'h12345AEF);
      load("t4.lw2", 32'h100, 1'b0, 1'b1, 32'h12345AEF);
      store("t4.sw", 3'b010, 32'h200, 32'hCAFEF00D, 1'b0);
      load("t4.lw3", 32'h100, 1'b0, 1'b1, 32'h12345AEF);
      load("t4.lw4", 32'h200, 1'b1, 1'b1, 32'hCAFEF00D);

      // T5 reset during RDATA
      ram_ce_i = 1'b1; ram_we_i = 1'b0; ram_sel_i = 3'b010; ram_addr_i = 32'h100;
      @(negedge clk);
      chk("t5.stall", {31'b0, stall_req_o}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("t5.rdata_stall", {31'b0, stall_req_o}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; ram_ce_i = 1'b0;
      @(negedge clk);
      chk("t5.idle_stall", {31'b0, stall_req_o}, 32'd0);
      chk("t5.idle_data",  ram_data_o,           32'h0);
      @(posedge clk); #1;
      load("t5.lw", 32'h100, 1'b1, 1'b1, 32'h12345AEF);

      // T6 misaligned half, illegal sel, out-of-range word store
      store("t6.sh_mis", 3'b001, 32'h101, 32'h0000FFFF, ERR);
      load("t6.lw1", 32'h100, !ERR, 1'b1, 32'h12345AEF);
      store("t6.sel7", 3'b111, 32'h100, 32'h00000000, ERR);
      load("t6.lw2", 32'h100, !ERR, 1'b1, 32'h12345AEF);
      store("t6.oor", 3'b010, 32'h4100, 32'hA5A5A5A5, ERR);
      load("t6.lw3", 32'h100, !ERR, 1'b1, ERR ? 32'h12345AEF : 32'hA5A5A5A5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
